// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat datapath: deal destinations and scheduler states.
package baccarat_pkg;

    localparam int unsigned DEST_NUM = 6;
    localparam int unsigned DEST_W   = 3;

    typedef enum logic [DEST_W-1:0] {
        DEST_P1 = 3'd0,
        DEST_P2 = 3'd1,
        DEST_P3 = 3'd2,
        DEST_D1 = 3'd3,
        DEST_D2 = 3'd4,
        DEST_D3 = 3'd5
    } dest_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHUFFLE,
        ST_READY,
        ST_FETCH,
        ST_LOAD
    } sched_state_t;

    function automatic logic dest_legal(input logic [DEST_W-1:0] d);
        return d <= DEST_D3;
    endfunction

endpackage

// File: rtl/deal_timeout_counter.sv
// Counts FETCH cycles without a card; flags the cycle in which the wait budget runs out.
module deal_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates at TIMEOUT so a stalled source can never wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/deal_scheduler.sv
// Arbitrates the single card source among the six hand slots: fetches one card per
// deal command, pulses the matching load strobe and forces reshuffles at the cut level.
module deal_scheduler
    import baccarat_pkg::*;
#(
    parameter int unsigned SHOE_CARDS = 312,
    parameter int unsigned CUT_LEVEL  = 16,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 9
) (
    input  logic                slow_clock,
    input  logic                reset,
    input  logic                round_start,
    input  logic                deal_req,
    input  logic [DEST_W-1:0]   deal_dest,
    output logic                deal_ack,
    output logic                round_ready,
    output logic                card_req,
    input  logic                card_valid,
    input  logic [3:0]          card_in,
    output logic [3:0]          card_out,
    output logic [DEST_NUM-1:0] load_strobe,
    output logic                shuffle_req,
    input  logic                shuffle_done,
    output logic [CNT_W-1:0]    cards_left,
    output logic                err_dest,
    output logic                err_timeout
);

    sched_state_t          state_q, state_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [3:0]            card_out_q, card_out_d;
    logic [CNT_W-1:0]      cards_left_q, cards_left_d;
    logic                  err_dest_q, err_dest_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  deal_ack_q, deal_ack_d;
    logic                  round_ready_q, round_ready_d;
    logic                  card_req_q, card_req_d;
    logic                  shuffle_req_q, shuffle_req_d;
    logic [DEST_NUM-1:0]   load_strobe_q, load_strobe_d;
    logic                  bad_dest_ack;
    logic                  below_cut;
    logic                  tmr_clear;
    logic                  tmr_en;
    logic                  tmr_expired;

    assign below_cut = cards_left_q < CNT_W'(CUT_LEVEL);

    deal_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (slow_clock),
        .rst       (reset),
        .clear     (tmr_clear),
        .enable    (tmr_en),
        .expired_c (tmr_expired)
    );

    // Next state and datapath; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        card_out_d    = card_out_q;
        cards_left_d  = cards_left_q;
        err_dest_d    = err_dest_q;
        err_timeout_d = err_timeout_q;
        bad_dest_ack  = 1'b0;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (round_start) begin
                    state_d = below_cut ? ST_SHUFFLE : ST_READY;
                end
            end
            ST_SHUFFLE: begin
                if (shuffle_done) begin
                    cards_left_d = CNT_W'(SHOE_CARDS);
                    state_d      = ST_READY;
                end
            end
            ST_READY: begin
                // A request still high while our ack is visible is the one just served.
                if (round_start) begin
                    if (below_cut) begin
                        state_d = ST_SHUFFLE;
                    end
                end else if (deal_req && !deal_ack_q) begin
                    if (!dest_legal(deal_dest)) begin
                        err_dest_d   = 1'b1;
                        bad_dest_ack = 1'b1;
                    end else if (cards_left_q == '0) begin
                        state_d = ST_SHUFFLE;
                    end else begin
                        dest_d    = deal_dest;
                        tmr_clear = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                tmr_en = 1'b1;
                if (card_valid) begin
                    card_out_d = card_in;
                    if (cards_left_q != '0) begin
                        cards_left_d = cards_left_q - CNT_W'(1);
                    end
                    state_d = ST_LOAD;
                end else if (tmr_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        round_ready_d = (state_d == ST_READY);
        card_req_d    = (state_d == ST_FETCH);
        shuffle_req_d = (state_d == ST_SHUFFLE);
        deal_ack_d    = bad_dest_ack || (state_d == ST_LOAD);
        load_strobe_d = (state_d == ST_LOAD) ? (DEST_NUM'(1) << dest_q) : '0;
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dest_q        <= '0;
            card_out_q    <= '0;
            cards_left_q  <= '0;
            err_dest_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            deal_ack_q    <= 1'b0;
            round_ready_q <= 1'b0;
            card_req_q    <= 1'b0;
            shuffle_req_q <= 1'b0;
            load_strobe_q <= '0;
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            card_out_q    <= card_out_d;
            cards_left_q  <= cards_left_d;
            err_dest_q    <= err_dest_d;
            err_timeout_q <= err_timeout_d;
            deal_ack_q    <= deal_ack_d;
            round_ready_q <= round_ready_d;
            card_req_q    <= card_req_d;
            shuffle_req_q <= shuffle_req_d;
            load_strobe_q <= load_strobe_d;
        end
    end

    assign deal_ack    = deal_ack_q;
    assign round_ready = round_ready_q;
    assign card_req    = card_req_q;
    assign card_out    = card_out_q;
    assign load_strobe = load_strobe_q;
    assign shuffle_req = shuffle_req_q;
    assign cards_left  = cards_left_q;
    assign err_dest    = err_dest_q;
    assign err_timeout = err_timeout_q;

endmodule
